// File: rtl/ps2_cmd_controller.sv
// PS/2 host-to-device command sequencer: bus inhibit, request-to-send, bit shift,
// line-ACK check, response-byte wait with resend retries, and an overall timeout.
module ps2_cmd_controller #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MAX_RETRY      = 2
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       psClk_in,
    input  logic       psData_in,
    output logic       psClk_oe,
    output logic       psData_oe,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_byte,
    output logic       cmd_ready,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       rx_hold,
    output logic       done,
    output logic [1:0] status,
    output logic       busy
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    // The RTS cycle and the final counted cycle both belong to the budget, so DONE
    // lands exactly TIMEOUT_CYCLES after RTS.
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 2);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_RTS       = 3'd2;
    localparam logic [2:0] S_SHIFT     = 3'd3;
    localparam logic [2:0] S_LINE_ACK  = 3'd4;
    localparam logic [2:0] S_WAIT_RESP = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_NO_ACK  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_NACK    = 2'b11;

    localparam logic [7:0] RESP_ACK    = 8'hFA;
    localparam logic [7:0] RESP_RESEND = 8'hFE;

    logic [2:0]       r_state;
    logic [1:0]       r_clk_sync;
    logic [1:0]       r_data_sync;
    logic             r_clk_prev;
    logic [7:0]       r_cmd;
    logic             r_parity;
    logic             r_data_oe;
    logic [3:0]       r_bit_idx;
    logic [INH_W-1:0] r_inh_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic [RTY_W-1:0] r_retry;
    logic [1:0]       r_status;

    logic w_fe;
    logic w_data_s;
    logic w_timeout;
    logic w_shift_bit;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_prev  <= 1'b1;
        end else begin
            // NOTE: non-blocking so each stage captures the previous stage's old value.
            r_clk_sync  <= {r_clk_sync[0], psClk_in};
            r_data_sync <= {r_data_sync[0], psData_in};
            r_clk_prev  <= r_clk_sync[1];
        end
    end

    assign w_fe        = r_clk_prev & ~r_clk_sync[1];
    assign w_data_s    = r_data_sync[1];
    assign w_timeout   = (r_to_cnt == TO_LAST);
    // Index 0..7 selects data bits LSB first, index 8 selects parity.
    assign w_shift_bit = r_bit_idx[3] ? r_parity : r_cmd[r_bit_idx[2:0]];

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cmd     <= 8'h00;
            r_parity  <= 1'b0;
            r_data_oe <= 1'b0;
            r_bit_idx <= 4'd0;
            r_inh_cnt <= '0;
            r_to_cnt  <= '0;
            r_retry   <= '0;
            r_status  <= ST_OK;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_cmd     <= cmd_byte;
                        r_parity  <= ~^cmd_byte;
                        r_retry   <= '0;
                        r_inh_cnt <= '0;
                        r_state   <= S_INHIBIT;
                    end
                end

                S_INHIBIT: begin
                    if (r_inh_cnt == INH_LAST) begin
                        r_state <= S_RTS;
                    end else begin
                        r_inh_cnt <= r_inh_cnt + INH_W'(1);
                    end
                end

                S_RTS: begin
                    r_to_cnt  <= '0;
                    r_bit_idx <= 4'd0;
                    r_data_oe <= 1'b1;
                    r_state   <= S_SHIFT;
                end

                S_SHIFT: begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                    if (w_timeout) begin
                        r_status <= ST_TIMEOUT;
                        r_state  <= S_DONE;
                    end else if (w_fe) begin
                        if (r_bit_idx == 4'd9) begin
                            r_data_oe <= 1'b0;
                            r_state   <= S_LINE_ACK;
                        end else begin
                            r_data_oe <= ~w_shift_bit;
                            r_bit_idx <= r_bit_idx + 4'd1;
                        end
                    end
                end

                S_LINE_ACK: begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                    if (w_fe) begin
                        if (!w_data_s) begin
                            r_state <= S_WAIT_RESP;
                        end else begin
                            r_status <= ST_NO_ACK;
                            r_state  <= S_DONE;
                        end
                    end else if (w_timeout) begin
                        r_status <= ST_TIMEOUT;
                        r_state  <= S_DONE;
                    end
                end

                S_WAIT_RESP: begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                    if (rx_valid) begin
                        if (rx_byte == RESP_ACK) begin
                            r_status <= ST_OK;
                            r_state  <= S_DONE;
                        end else if (rx_byte == RESP_RESEND && r_retry < RTY_MAX) begin
                            r_retry   <= r_retry + RTY_W'(1);
                            r_inh_cnt <= '0;
                            r_state   <= S_INHIBIT;
                        end else begin
                            r_status <= ST_NACK;
                            r_state  <= S_DONE;
                        end
                    end else if (w_timeout) begin
                        r_status <= ST_TIMEOUT;
                        r_state  <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Bus drives decode straight from state so an async reset releases them at once.
    assign psClk_oe  = (r_state == S_INHIBIT);
    assign psData_oe = (r_state == S_RTS) | ((r_state == S_SHIFT) & r_data_oe);
    assign rx_hold   = (r_state == S_INHIBIT) | (r_state == S_RTS) |
                       (r_state == S_SHIFT)   | (r_state == S_LINE_ACK);
    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign status    = r_status;

endmodule
